rr_encode_arbiter: RTL and testbench
====================================

Name: rr_encode_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Uses a masked priority encoder (one-hot to 3-bit index) to pick the winner.
- Registers the grant, both one-hot and encoded, and holds it until the owner releases.
- Sits in front of any shared datapath unit; downstream logic consumes gnt_idx as the select.

Parameters:
- N, 8, number of requesters.
- W, 3, index width; must equal clog2(N).
- TIMEOUT, 16, maximum GRANT cycles before forced release. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N  request vector; bit i is held high by requester i while it wants or owns the resource.
- rel  in  1  one-cycle release pulse from the current owner.
- gnt  out  N  registered one-hot grant.
- gnt_vld  out  1  high when any grant is active.
- gnt_idx  out  W  encoded index of the granted requester; 0 when gnt_vld is low.
- timeout  out  1  one-cycle pulse on forced release. Constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: one clock, synchronous and active-high. With rst high at a rising edge:
  - state=IDLE, ptr=0.
  - gnt=0, gnt_vld=0, gnt_idx=0, timeout=0.
  - Timer cleared.
  - rst overrides everything, including mid-grant; no release bookkeeping occurs.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at edge N, go to GRANT at N. Outputs are valid after edge N.
  - Winner = first set bit of req scanning ptr, ptr+1, ..., wrapping N-1 to 0.
  - If req==0, stay in IDLE. rel is ignored in IDLE.
- GRANT:
  - Outputs hold stable while req[gnt_idx]=1 and rel=0.
  - Release condition = rel=1, or req[gnt_idx]=0 (requester withdraws).
  - On the release edge:
    - gnt, gnt_vld and gnt_idx clear.
    - ptr <= gnt_idx+1 mod N.
    - state <= IDLE.
  - One mandatory bubble cycle: if released at edge N, the next grant appears at edge N+1 at the earliest, after passing through IDLE.
  - rel and the owner's req staying high in the same cycle: release wins. The same requester can re-win only if no other requester sits ahead of it under the new ptr.
- Arbitration latency: 1 edge from request to grant in IDLE.
- Fairness: with all N requesting continuously, grants rotate 0,1,...,7,0 with no starvation.
- Requests from non-owners in GRANT are ignored until the state returns to IDLE; there is no queueing.
- Pointer wrap: ptr=7 with req=8'b1000_0001 grants 7; after release ptr=0, so the next grant is 0.
- Invariants: gnt is always one-hot or zero; gnt_vld == |gnt; gnt_idx is the encode of gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - A W_T = clog2(TIMEOUT) bit timer clears on GRANT entry and increments each GRANT cycle.
  - When the timer reaches TIMEOUT-1 and no other release condition holds, the block forces a release on that edge, with the same pointer update as a normal release.
  - timeout pulses high for exactly the following cycle.
  - A normal release in the same cycle as expiry takes precedence; timeout stays 0.
- Undefined: no timer is instantiated; timeout is tied to 0; a grant is held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=8 and IDX_W=3 constants.
  - The state enum {IDLE, GRANT}.
  - The default TIMEOUT constant.
- One sub-module, rr_pick (combinational):
  - Inputs: req[N-1:0], ptr[W-1:0].
  - Method: rotate req by ptr, priority-encode the lowest set bit, un-rotate.
  - Outputs: pick_oh[N-1:0], pick_idx[W-1:0], pick_any.
- The top level holds only the FSM, registers, ptr and the optional timer.

Test Plan:
- Reset: assert rst 2 cycles with req=8'hFF → gnt=0, gnt_vld=0, gnt_idx=0 throughout. After deassert: gnt=8'h01, gnt_idx=0 one edge later.
- Single requester: req=8'h10 from IDLE → next edge gnt=8'h10, gnt_idx=4. Pulse rel → next edge gnt=0. req still 8'h10 → regranted on the following edge.
- Round-robin: req=8'hFF held, rel pulsed each GRANT cycle → gnt_idx sequence 0,1,2,3,4,5,6,7,0, with exactly one idle cycle between grants.
- Wrap and withdraw: owner 6 drops req while req=8'h81 → release; ptr=7 → next grant idx 7, then idx 0 after rel.
- Mid-grant reset and ignored rel: in GRANT idx 3, assert rst → gnt=0 on that edge; after release from reset req=8'h08 → idx 3 granted (ptr=0). Separately, rel pulsed in IDLE with req=0 → no state change.
- ARB_TIMEOUT_EN, TIMEOUT=4: req=8'h04 held, no rel → gnt held 4 cycles, then forced release with timeout=1 for one cycle. Next grant idx 2 after the bubble. Without the macro: grant held 20+ cycles and timeout stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and FSM state type for the round-robin encode arbiter.
package arb_pkg;
    localparam int N_REQ       = 8;
    localparam int IDX_W       = 3;
    localparam int TIMEOUT_DEF = 16;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; rotate req by ptr, take lowest set bit, un-rotate.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = IDX_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] pick_oh,
    output logic [W-1:0] pick_idx,
    output logic         pick_any
);
    logic [N-1:0] w_rot;
    logic [W-1:0] w_low;
    logic [W:0]   w_sum;
    always_comb begin
        w_rot = N'({req, req} >> ptr);
        w_low = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_rot[i]) w_low = W'(i);
        w_sum    = {1'b0, w_low} + {1'b0, ptr};
        pick_idx = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
        pick_any = |req;
        pick_oh  = pick_any ? (N'(1) << pick_idx) : '0;
    end
endmodule

// File: rtl/rr_encode_arbiter.sv
// rr_encode_arbiter: 8-way round-robin arbiter with registered one-hot and encoded grant.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT grant cycles.
module rr_encode_arbiter
    import arb_pkg::*;
#(
    parameter int N       = N_REQ,
    parameter int W       = IDX_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         rel,
    output logic [N-1:0] gnt,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx,
    output logic         timeout
);
    state_t       r_state, w_next;
    logic [W-1:0] r_ptr, r_idx;
    logic [N-1:0] r_gnt;
    logic [N-1:0] w_pick_oh;
    logic [W-1:0] w_pick_idx;
    logic         w_pick_any, w_norm, w_force, w_release;

    if (W != $clog2(N) || TIMEOUT < 2) begin : g_bad_cfg
        $error("rr_encode_arbiter: W must equal clog2(N) and TIMEOUT must be at least 2");
    end

    rr_pick #(.N(N), .W(W)) u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick_oh  (w_pick_oh),
        .pick_idx (w_pick_idx),
        .pick_any (w_pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int W_T = $clog2(TIMEOUT);
    logic [W_T-1:0] r_timer;
    logic           r_timeout;
    // Timer sits at zero outside GRANT, so it is already clear on grant entry.
    always_ff @(posedge clk) begin
        r_timer   <= (rst || r_state != GRANT) ? '0 : r_timer + 1'b1;
        r_timeout <= !rst && w_force;
    end
    assign w_force = (r_state == GRANT) && !w_norm && (r_timer == W_T'(TIMEOUT - 1));
    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        w_norm    = (r_state == GRANT) && (rel || !req[r_idx]);
        w_release = w_norm || w_force;
        w_next    = (r_state == IDLE) ? (w_pick_any ? GRANT : IDLE)
                                      : (w_release ? IDLE : GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_pick_any) begin
                r_gnt <= w_pick_oh;
                r_idx <= w_pick_idx;
            end else if (w_release) begin
                r_gnt <= '0;
                r_idx <= '0;
                r_ptr <= (r_idx == W'(N - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = |r_gnt;
    assign gnt_idx = r_idx;
endmodule

// File: tb/tb_rr_encode_arbiter.sv
// tb_rr_encode_arbiter: directed vectors with hand-computed expectations for rr_encode_arbiter.
module tb_rr_encode_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic       timeout;
    int         total = 0;
    int         bad = 0;

    rr_encode_arbiter #(.N(8), .W(3), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] idx);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".vld"}, 32'(gnt_vld), 32'(g != 8'h00));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    endtask

    initial begin
        // reset held two edges with all requesting
        tick;
        chk_gnt("rst0", 8'h00, 3'd0);
        check("rst0.to", 32'(timeout), 32'd0);
        tick;
        chk_gnt("rst1", 8'h00, 3'd0);
        rst = 1'b0;
        tick;
        chk_gnt("post_rst", 8'h01, 3'd0);
        // rotation 1..7,0 with one bubble each
        for (int k = 1; k <= 8; k++) begin
            rel = 1'b1;
            tick;
            chk_gnt("rr_bubble", 8'h00, 3'd0);
            rel = 1'b0;
            tick;
            chk_gnt("rr_grant", 8'(1 << (k % 8)), 3'(k % 8));
        end
        // single requester, release and regrant
        req = 8'h00;
        tick;
        chk_gnt("withdraw0", 8'h00, 3'd0);
        tick;
        chk_gnt("idle_empty", 8'h00, 3'd0);
        req = 8'h10;
        tick;
        chk_gnt("single", 8'h10, 3'd4);
        rel = 1'b1;
        tick;
        chk_gnt("single_rel", 8'h00, 3'd0);
        rel = 1'b0;
        tick;
        chk_gnt("single_regrant", 8'h10, 3'd4);
        // wrap and withdraw
        req = 8'h40;
        tick;
        chk_gnt("wd4", 8'h00, 3'd0);
        tick;
        chk_gnt("own6", 8'h40, 3'd6);
        req = 8'h81;
        tick;
        chk_gnt("wd6", 8'h00, 3'd0);
        tick;
        chk_gnt("wrap7", 8'h80, 3'd7);
        rel = 1'b1;
        tick;
        chk_gnt("rel7", 8'h00, 3'd0);
        rel = 1'b0;
        tick;
        chk_gnt("wrap0", 8'h01, 3'd0);
        // mid-grant reset
        req = 8'h08;
        tick;
        chk_gnt("wd0", 8'h00, 3'd0);
        tick;
        chk_gnt("own3", 8'h08, 3'd3);
        rst = 1'b1;
        tick;
        chk_gnt("mid_rst", 8'h00, 3'd0);
        rst = 1'b0;
        tick;
        chk_gnt("after_rst", 8'h08, 3'd3);
        // rel in IDLE is ignored; ptr stays 4 so bit 0 wins over bit 3
        req = 8'h00;
        tick;
        chk_gnt("wd3", 8'h00, 3'd0);
        rel = 1'b1;
        tick;
        chk_gnt("idle_rel", 8'h00, 3'd0);
        rel = 1'b0;
        req = 8'h09;
        tick;
        chk_gnt("ptr4_pick", 8'h01, 3'd0);
        // long hold
        req = 8'h04;
        tick;
        chk_gnt("wd0b", 8'h00, 3'd0);
        tick;
        chk_gnt("hold_start", 8'h04, 3'd2);
        check("hold_start.to", 32'(timeout), 32'd0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick;
            chk_gnt("to_hold", 8'h04, 3'd2);
            check("to_hold.to", 32'(timeout), 32'd0);
        end
        tick;
        chk_gnt("to_force", 8'h00, 3'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        tick;
        chk_gnt("to_regrant", 8'h04, 3'd2);
        check("to_pulse_end", 32'(timeout), 32'd0);
`else
        for (int k = 0; k < 22; k++) begin
            tick;
            chk_gnt("hold", 8'h04, 3'd2);
            check("hold.to", 32'(timeout), 32'd0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
